// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the register-file/ALU datapath.
// Accepts CR16-style instructions and direct register loads over valid/ready,
// steps FETCH/DECODE/EXEC/WB (or LOAD), and owns the processor status register.
module alu_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic        i_ld_valid,
  input  logic [3:0]  i_ld_addr,
  output logic        o_ld_ready,
  input  logic [4:0]  i_alu_flags,
  output logic [3:0]  o_raddr_a,
  output logic [3:0]  o_raddr_b,
  output logic [15:0] o_imm,
  output logic        o_imm_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_cin,
  output logic        o_wb_sel,
  output logic [15:0] o_reg_en,
  output logic [4:0]  o_psr,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StLoad
  } state_e;

  localparam logic [3:0] OpAddi  = 4'b0101;
  localparam logic [3:0] OpAddci = 4'b0111;
  localparam logic [3:0] OpSubi  = 4'b1001;
  localparam logic [3:0] OpSubci = 4'b1010;
  localparam logic [3:0] OpCmp   = 4'b1011;
  localparam logic [3:0] OpMov   = 4'b1101;
  localparam logic [3:0] OpLui   = 4'b1111;

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_ir;
  logic [3:0]  r_ld_addr;
  logic [4:0]  r_psr;

  logic        w_instr_acc;
  logic        w_ld_acc;
  logic        w_psr_we;
  logic        w_rtype;
  logic        w_sext;
  logic [3:0]  w_alu_op;

  // State, instruction, load-address and PSR registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StFetch;
      r_ir      <= 16'h0000;
      r_ld_addr <= 4'h0;
      r_psr     <= 5'b00000;
    end else begin
      r_state <= w_state_next;
      if (w_instr_acc) r_ir <= i_instr;
      if (w_ld_acc) r_ld_addr <= i_ld_addr;
      if (w_psr_we) r_psr <= i_alu_flags;
    end
  end

  // Combinational decode of the latched instruction word.
  always_comb begin
    w_rtype   = (r_ir[15:12] == 4'b0000);
    w_alu_op  = w_rtype ? r_ir[7:4] : r_ir[15:12];
    w_sext    = (w_alu_op == OpAddi) || (w_alu_op == OpAddci) || (w_alu_op == OpSubi) ||
                (w_alu_op == OpSubci) || (w_alu_op == OpCmp);
    o_alu_op  = w_alu_op;
    o_raddr_a = r_ir[11:8];
    o_raddr_b = w_rtype ? r_ir[3:0] : 4'h0;
    o_imm_sel = ~w_rtype;
    if (w_rtype) begin
      o_imm = 16'h0000;
    end else if (w_sext) begin
      o_imm = {{8{r_ir[7]}}, r_ir[7:0]};
    end else begin
      o_imm = {8'h00, r_ir[7:0]};
    end
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    w_state_next  = r_state;
    w_instr_acc   = 1'b0;
    w_ld_acc      = 1'b0;
    w_psr_we      = 1'b0;
    o_instr_ready = 1'b0;
    o_ld_ready    = 1'b0;
    o_wb_sel      = 1'b0;
    o_reg_en      = 16'h0000;
    o_done        = 1'b0;
    o_busy        = 1'b1;
    unique case (r_state)
      StFetch: begin
        o_busy        = 1'b0;
        o_ld_ready    = 1'b1;
        // Loads take priority; the instruction stays pending until a load-free FETCH.
        o_instr_ready = ~i_ld_valid;
        if (i_ld_valid) begin
          w_ld_acc     = 1'b1;
          w_state_next = StLoad;
        end else if (i_instr_valid) begin
          w_instr_acc  = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        w_state_next = StExec;
      end
      StExec: begin
        // MOV/MOVI and LUI leave the flags untouched.
        w_psr_we     = (w_alu_op != OpMov) && (w_alu_op != OpLui);
        w_state_next = StWb;
      end
      StWb: begin
        o_wb_sel     = 1'b1;
        o_done       = 1'b1;
        o_reg_en     = (w_alu_op == OpCmp) ? 16'h0000 : (16'h0001 << r_ir[11:8]);
        w_state_next = StFetch;
      end
      StLoad: begin
        o_done       = 1'b1;
        o_reg_en     = 16'h0001 << r_ld_addr;
        w_state_next = StFetch;
      end
      default: begin
        w_state_next = StFetch;
      end
    endcase
  end

  assign o_psr = r_psr;
  assign o_cin = r_psr[4];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer. Inputs change and outputs are
// sampled on the falling clock edge, half a cycle away from the active edge.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic        ld_ready;
  logic [4:0]  alu_flags;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic [15:0] imm;
  logic        imm_sel;
  logic [3:0]  alu_op;
  logic        cin;
  logic        wb_sel;
  logic [15:0] reg_en;
  logic [4:0]  psr;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_instr       (instr),
    .i_instr_valid (instr_valid),
    .o_instr_ready (instr_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_addr     (ld_addr),
    .o_ld_ready    (ld_ready),
    .i_alu_flags   (alu_flags),
    .o_raddr_a     (raddr_a),
    .o_raddr_b     (raddr_b),
    .o_imm         (imm),
    .o_imm_sel     (imm_sel),
    .o_alu_op      (alu_op),
    .o_cin         (cin),
    .o_wb_sel      (wb_sel),
    .o_reg_en      (reg_en),
    .o_psr         (psr),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL rst_reg_en got %h want 0000", reg_en); end
    n_cmp++; if (wb_sel !== 1'b0) begin n_err++; $display("FAIL rst_wb_sel got %b want 0", wb_sel); end
    n_cmp++; if (psr !== 5'b00000) begin n_err++; $display("FAIL rst_psr got %b want 00000", psr); end
    n_cmp++; if (alu_op !== 4'h0) begin n_err++; $display("FAIL rst_alu_op got %h want 0", alu_op); end
    n_cmp++; if (raddr_a !== 4'h0) begin n_err++; $display("FAIL rst_raddr_a got %h want 0", raddr_a); end
    n_cmp++; if (raddr_b !== 4'h0) begin n_err++; $display("FAIL rst_raddr_b got %h want 0", raddr_b); end
    n_cmp++; if (imm !== 16'h0000) begin n_err++; $display("FAIL rst_imm got %h want 0000", imm); end
    n_cmp++; if (imm_sel !== 1'b0) begin n_err++; $display("FAIL rst_imm_sel got %b want 0", imm_sel); end
    n_cmp++; if (cin !== 1'b0) begin n_err++; $display("FAIL rst_cin got %b want 0", cin); end
    reset = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_instr_ready got %b want 1", instr_ready); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready got %b want 1", ld_ready); end
  endtask

  // ADD r1,r2: full four-cycle sequence with cycle-accurate checks.
  task automatic test_add_rtype;
    @(negedge clk);
    instr = 16'h0152; instr_valid = 1'b1; alu_flags = 5'b00000;
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL add_ready0 got %b want 1", instr_ready); end
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy_dec got %b want 1", busy); end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL add_ready_dec got %b want 0", instr_ready); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL add_reg_en_dec got %h want 0000", reg_en); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_dec got %b want 0", done); end
    @(negedge clk); // EXEC
    n_cmp++; if (raddr_a !== 4'd1) begin n_err++; $display("FAIL add_raddr_a got %h want 1", raddr_a); end
    n_cmp++; if (raddr_b !== 4'd2) begin n_err++; $display("FAIL add_raddr_b got %h want 2", raddr_b); end
    n_cmp++; if (alu_op !== 4'b0101) begin n_err++; $display("FAIL add_alu_op got %b want 0101", alu_op); end
    n_cmp++; if (imm_sel !== 1'b0) begin n_err++; $display("FAIL add_imm_sel got %b want 0", imm_sel); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL add_reg_en_ex got %h want 0000", reg_en); end
    n_cmp++; if (wb_sel !== 1'b0) begin n_err++; $display("FAIL add_wb_sel_ex got %b want 0", wb_sel); end
    @(negedge clk); // WB
    n_cmp++; if (reg_en !== 16'h0002) begin n_err++; $display("FAIL add_reg_en_wb got %h want 0002", reg_en); end
    n_cmp++; if (wb_sel !== 1'b1) begin n_err++; $display("FAIL add_wb_sel_wb got %b want 1", wb_sel); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL add_done_wb got %b want 1", done); end
    @(negedge clk); // FETCH
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL add_ready4 got %b want 1", instr_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done4 got %b want 0", done); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL add_reg_en4 got %h want 0000", reg_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy4 got %b want 0", busy); end
  endtask

  // ADDI sign-extends its immediate; ANDI zero-extends.
  task automatic test_imm_ext;
    @(negedge clk);
    instr = 16'h53F0; instr_valid = 1'b1;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (imm !== 16'hFFF0) begin n_err++; $display("FAIL addi_imm got %h want fff0", imm); end
    n_cmp++; if (imm_sel !== 1'b1) begin n_err++; $display("FAIL addi_imm_sel got %b want 1", imm_sel); end
    n_cmp++; if (alu_op !== 4'b0101) begin n_err++; $display("FAIL addi_alu_op got %b want 0101", alu_op); end
    n_cmp++; if (raddr_b !== 4'd0) begin n_err++; $display("FAIL addi_raddr_b got %h want 0", raddr_b); end
    @(negedge clk); // EXEC
    @(negedge clk); // WB
    n_cmp++; if (reg_en !== 16'h0008) begin n_err++; $display("FAIL addi_reg_en got %h want 0008", reg_en); end
    @(negedge clk); // FETCH
    instr = 16'h13F0; instr_valid = 1'b1;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (imm !== 16'h00F0) begin n_err++; $display("FAIL andi_imm got %h want 00f0", imm); end
    n_cmp++; if (alu_op !== 4'b0001) begin n_err++; $display("FAIL andi_alu_op got %b want 0001", alu_op); end
    @(negedge clk); // EXEC
    @(negedge clk); // WB
    n_cmp++; if (reg_en !== 16'h0008) begin n_err++; $display("FAIL andi_reg_en got %h want 0008", reg_en); end
    @(negedge clk); // FETCH
  endtask

  // CMP updates flags but never writes a register.
  task automatic test_cmp;
    @(negedge clk);
    instr = 16'h0BB4; instr_valid = 1'b1; alu_flags = 5'b00010;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL cmp_reg_en_dec got %h want 0000", reg_en); end
    n_cmp++; if (alu_op !== 4'b1011) begin n_err++; $display("FAIL cmp_alu_op got %b want 1011", alu_op); end
    n_cmp++; if (raddr_b !== 4'd4) begin n_err++; $display("FAIL cmp_raddr_b got %h want 4", raddr_b); end
    @(negedge clk); // EXEC
    n_cmp++; if (psr !== 5'b00000) begin n_err++; $display("FAIL cmp_psr_ex got %b want 00000", psr); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL cmp_reg_en_ex got %h want 0000", reg_en); end
    @(negedge clk); // WB
    n_cmp++; if (psr !== 5'b00010) begin n_err++; $display("FAIL cmp_psr_wb got %b want 00010", psr); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL cmp_reg_en_wb got %h want 0000", reg_en); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cmp_done_wb got %b want 1", done); end
    @(negedge clk); // FETCH
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cmp_done_f got %b want 0", done); end
  endtask

  // Simultaneous load and instruction: load first, instruction two cycles later.
  task automatic test_load_priority;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 4'd7; instr = 16'h0152; instr_valid = 1'b1;
    alu_flags = 5'b00100;
    #1;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL ld_instr_ready got %b want 0", instr_ready); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_ld_ready got %b want 1", ld_ready); end
    @(negedge clk); // LOAD
    n_cmp++; if (reg_en !== 16'h0080) begin n_err++; $display("FAIL ld_reg_en got %h want 0080", reg_en); end
    n_cmp++; if (wb_sel !== 1'b0) begin n_err++; $display("FAIL ld_wb_sel got %b want 0", wb_sel); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ld_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ld_busy got %b want 1", busy); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ld_ld_ready_l got %b want 0", ld_ready); end
    ld_valid = 1'b0;
    @(negedge clk); // FETCH, instruction accepted at the next edge
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ld_instr_ready_f got %b want 1", instr_ready); end
    n_cmp++; if (reg_en !== 16'h0000) begin n_err++; $display("FAIL ld_reg_en_f got %h want 0000", reg_en); end
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ld_instr_acc got %b want 1", busy); end
    n_cmp++; if (raddr_a !== 4'd1) begin n_err++; $display("FAIL ld_instr_raddr_a got %h want 1", raddr_a); end
    @(negedge clk); // EXEC
    @(negedge clk); // WB
    n_cmp++; if (reg_en !== 16'h0002) begin n_err++; $display("FAIL ld_instr_reg_en got %h want 0002", reg_en); end
    @(negedge clk); // FETCH
    n_cmp++; if (psr !== 5'b00100) begin n_err++; $display("FAIL ld_instr_psr got %b want 00100", psr); end
  endtask

  // Reset during EXEC drops the instruction: no write, no done, psr cleared.
  task automatic test_reset_mid_exec;
    @(negedge clk);
    instr = 16'h0556; instr_valid = 1'b1;
    @(negedge clk); // DECODE
    instr_valid = 1'b0; alu_flags = 5'b11111;
    @(negedge clk); // EXEC
    n_cmp++; if (raddr_b !== 4'd6) begin n_err++; $display("FAIL rx_raddr_b got %h want 6", raddr_b); end
    n_cmp++; if (psr !== 5'b00100) begin n_err++; $display("FAIL rx_psr_ex got %b want 00100", psr); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (psr !== 5'b00000) begin n_err++; $display("FAIL rx_psr got %b want 00000", psr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rx_busy got %b want 0", busy); end
    n_cmp++; if (alu_op !== 4'h0) begin n_err++; $display("FAIL rx_alu_op got %h want 0", alu_op); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (reg_en !== 16'h0000 || done !== 1'b0) begin
        n_err++;
        $display("FAIL rx_quiet[%0d] got reg_en=%h done=%b want 0000/0", i, reg_en, done);
      end
      @(negedge clk);
    end
  endtask

  // ADDC sees C from the prior op; MOVI leaves psr alone.
  task automatic test_addc_movi;
    alu_flags = 5'b10000;
    instr = 16'h0152; instr_valid = 1'b1;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    repeat (3) @(negedge clk); // EXEC, WB, FETCH
    n_cmp++; if (psr !== 5'b10000) begin n_err++; $display("FAIL addc_pre_psr got %b want 10000", psr); end
    instr = 16'h0172; instr_valid = 1'b1;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (cin !== 1'b1) begin n_err++; $display("FAIL addc_cin_dec got %b want 1", cin); end
    n_cmp++; if (alu_op !== 4'b0111) begin n_err++; $display("FAIL addc_alu_op got %b want 0111", alu_op); end
    @(negedge clk); // EXEC
    n_cmp++; if (cin !== 1'b1) begin n_err++; $display("FAIL addc_cin_ex got %b want 1", cin); end
    @(negedge clk); // WB
    n_cmp++; if (cin !== 1'b1) begin n_err++; $display("FAIL addc_cin_wb got %b want 1", cin); end
    @(negedge clk); // FETCH
    instr = 16'hD123; instr_valid = 1'b1; alu_flags = 5'b00001;
    @(negedge clk); // DECODE
    instr_valid = 1'b0;
    n_cmp++; if (imm !== 16'h0023) begin n_err++; $display("FAIL movi_imm got %h want 0023", imm); end
    n_cmp++; if (alu_op !== 4'b1101) begin n_err++; $display("FAIL movi_alu_op got %b want 1101", alu_op); end
    @(negedge clk); // EXEC
    @(negedge clk); // WB
    n_cmp++; if (psr !== 5'b10000) begin n_err++; $display("FAIL movi_psr got %b want 10000", psr); end
    n_cmp++; if (reg_en !== 16'h0002) begin n_err++; $display("FAIL movi_reg_en got %h want 0002", reg_en); end
    @(negedge clk); // FETCH
    n_cmp++; if (psr !== 5'b10000) begin n_err++; $display("FAIL movi_psr_f got %b want 10000", psr); end
  endtask

  initial begin
    reset       = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = 4'h0;
    alu_flags   = 5'b00000;
    test_reset();
    test_add_rtype();
    test_imm_ext();
    test_cmp();
    test_load_priority();
    test_reset_mid_exec();
    test_addc_movi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that drives the register-file/ALU datapath. It accepts 16-bit CR16-style instructions and direct register-load requests through valid/ready handshakes. It decodes each instruction and steps the datapath through FETCH/DECODE/EXEC/WB, producing every mux select, read address, ALU opcode and one-hot register write enable. It owns the processor status register (PSR) and supplies ALU carry-in from it.

## Interface
- No parameters. Widths fixed: 16-bit data, 16 registers, 5 flags.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- instr  in  16  instruction word; sampled when instr_valid & instr_ready
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in FETCH when ld_valid is low
- ld_valid  in  1  direct-load request (datapath inData -> register ld_addr)
- ld_addr  in  4  destination register of direct load
- ld_ready  out  1  high only in FETCH
- alu_flags  in  5  ALU flags {C,L,F,Z,N}, valid combinationally in EXEC
- raddr_a  out  4  regfile port A address (rdest)
- raddr_b  out  4  regfile port B address (rsrc)
- imm  out  16  extended immediate
- imm_sel  out  1  1 selects imm onto ALU B, 0 selects rdata_b
- alu_op  out  4  ALU opcode
- cin  out  1  ALU carry-in = psr[4] (C)
- wb_sel  out  1  regfile write-data select: 0 inData, 1 ALU result
- reg_en  out  16  one-hot register write enable
- psr  out  5  status register {C,L,F,Z,N}
- busy  out  1  high in any state other than FETCH
- done  out  1  one-cycle pulse when an instruction or load retires

## Operation
- IR (16b) latches instr on accept. Load address register latches ld_addr on load accept.
- Decode is combinational from IR and is stable from DECODE through WB:
  - IR[15:12]==0000 (R-type): alu_op=IR[7:4], raddr_a=IR[11:8], raddr_b=IR[3:0], imm_sel=0, imm=0.
  - Otherwise (I-type): alu_op=IR[15:12], raddr_a=IR[11:8], raddr_b=0, imm_sel=1.
- Immediate extension:
  - Sign-extend IR[7:0] for alu_op in {0101 ADDI, 0111 ADDCI, 1001 SUBI, 1010 SUBCI, 1011 CMPI}.
  - Zero-extend for all other I-type opcodes.
- States:
  - FETCH: Load has priority. If ld_valid, accept load -> LOAD. Else if instr_valid, accept instr -> DECODE. Else stay in FETCH.
  - DECODE: one cycle -> EXEC.
  - EXEC: ALU operates. At the cycle end, psr<=alu_flags unless alu_op is 1101 (MOV/MOVI) or 1111 (LUI). -> WB.
  - WB: wb_sel=1. reg_en=1<<raddr_a, except reg_en=0 when alu_op==1011 (CMP/CMPI). done=1. -> FETCH.
  - LOAD: wb_sel=0, reg_en=1<<ld_addr, done=1 -> FETCH.
- reg_en is zero in every state except WB and LOAD, and is never more than one-hot.
- Writes to r0 are permitted; the regfile handles r0 like any other register.
- wb_sel=0 outside WB.

## Timing
- Reset values: state=FETCH, IR=0, load address=0, psr=0, reg_en=0, wb_sel=0, done=0, busy=0. Decoded outputs follow IR=0: alu_op=0, raddr_a=0, raddr_b=0, imm=0, imm_sel=0, cin=0.
- Reset is a synchronous override in any state. The in-flight instruction or load is dropped, no register write occurs, and psr is cleared.
- Instruction accepted at edge T0: DECODE in cycle 1, EXEC in cycle 2, WB in cycle 3 (regfile captures at end of cycle 3). FETCH in cycle 4, earliest next accept at end of cycle 4. Throughput is 1 instruction per 4 cycles.
- Load accepted at T0: LOAD in cycle 1 (write at its end), FETCH in cycle 2. Throughput is 1 load per 2 cycles.
- psr is updated at the end of EXEC. An instruction's cin therefore reflects flags from the previous flag-setting instruction, never its own.
- ld_valid and instr_valid both high in FETCH: the load wins. instr_ready is low, so the instruction stays pending and is accepted on the next FETCH with ld_valid low.
- Requesters hold valid and payload until accepted. Valid deasserting without acceptance is legal and has no effect.

## Test plan
- Reset, then instr=0x0152 (ADD r1,r2) valid at cycle 0. Required: raddr_a=1, raddr_b=2, alu_op=0101, imm_sel=0 in EXEC. reg_en=0x0002, wb_sel=1, done=1 in cycle 3 only. instr_ready high again in cycle 4.
- instr=0x53F0 (ADDI r3,-16). Required: imm=0xFFF0, imm_sel=1, reg_en=0x0008 in WB. instr=0x13F0 (ANDI). Required: imm=0x00F0.
- instr=0x0BB4 (CMP r11,r4) with alu_flags=5'b00010. Required: psr=00010 after EXEC, reg_en=0 throughout, done pulses in WB.
- ld_valid=1 with ld_addr=7 and instr_valid=1 together in FETCH. Required: load accepted, instr_ready=0, reg_en=0x0080 with wb_sel=0 next cycle. The instruction is accepted 2 cycles after the load.
- reset asserted during EXEC of ADD r5,r6 with alu_flags=11111. Required: next cycle in FETCH, psr=0, reg_en never nonzero, done not pulsed.
- ADDC (R-type, alu_op=0111) after an op leaving C=1. Required: cin=1 from DECODE through WB. After a MOVI that follows, psr remains unchanged.
